stash_scan_scheduler: RTL and testbench
=======================================

STASH_SCAN_SCHEDULER -- requirements
Module: stash_scan_scheduler
Interface
REQ-001 SHALL have parameters ORAML (32): leaf width; ORAMU (32): program-address width; ORAMZ (4): blocks per bucket.
REQ-002 SHALL have parameters StashEAWidth (7): stash entry address width; StashCapacity (100): entries scanned; ScanTableAWidth (8): scan-table address width; BlocksOnPath ((ORAML+1)*ORAMZ): scan-table depth; SNULL (all ones): empty marker.
REQ-003 SHALL have ports: Clock in 1, single clock; Reset in 1, synchronous active-high reset.
REQ-004 SHALL have ports: Start in 1, access request; StartLeaf in ORAML, access leaf; Busy out 1, access in progress; Done out 1, one-cycle completion pulse; AcceptedCount out StashEAWidth, entries accepted this access.
REQ-005 SHALL have ports: MetaAddr out StashEAWidth; MetaRead out 1; MetaValid in 1, entry occupied; MetaLeaf in ORAML; MetaPAddr in ORAMU (MetaValid/MetaLeaf/MetaPAddr return 1 cycle after MetaRead).
REQ-006 SHALL have scan-table drive ports: PerAccessReset out 1; CurrentLeaf out ORAML; CurrentLeafValid out 1; InScanLeaf out ORAML; InScanPAddr out ORAMU; InScanSAddr out StashEAWidth; InScanValid out 1; InDMAAddr out ScanTableAWidth; InDMAValid out 1; InDMAReset out 1.
REQ-007 SHALL have scan-table return ports: ResetDone in 1; OutScanAccepted in 1; OutDMAAddr in StashEAWidth; OutDMAValid in 1, 1 cycle after InDMAValid.
REQ-008 SHALL have writeback ports: WBSAddr out StashEAWidth; WBValid out 1; WBReady in 1, transfer when WBValid&WBReady.
Function
REQ-009 SHALL implement states IDLE, PRESET, SCAN, DRAIN, CLEAR.
REQ-010 SHALL accept Start only in IDLE with ResetDone=1; otherwise Start is ignored; Busy = (state!=IDLE) | ~ResetDone.
REQ-011 On accept SHALL latch StartLeaf into CurrentLeaf, enter PRESET, assert PerAccessReset exactly one cycle, clear AcceptedCount, then enter SCAN.
REQ-012 CurrentLeaf SHALL hold constant from accept until Done; CurrentLeafValid=1 in SCAN and DRAIN only.
REQ-013 SCAN SHALL issue MetaRead one per cycle at MetaAddr 0..StashCapacity-1; one cycle later drive InScanValid=MetaValid, InScanSAddr=delayed MetaAddr, InScanLeaf=MetaLeaf, InScanPAddr=MetaPAddr.
REQ-014 AcceptedCount SHALL increment on each cycle with OutScanAccepted=1; SCAN->DRAIN after the last read's response cycle.
REQ-015 InDMAValid/InDMAReset SHALL never be asserted in a cycle with InScanValid=1.
REQ-016 DRAIN SHALL read scan-table addresses 0..BlocksOnPath-1 in order via InDMAAddr/InDMAValid, issuing a read only when FIFO occupancy plus reads in flight < 2.
REQ-017 Each OutDMAValid SHALL enqueue OutDMAAddr into a 2-entry FIFO driving WBSAddr/WBValid; order preserved; no entry lost or duplicated under any WBReady pattern.
REQ-018 DRAIN->CLEAR when all reads are returned and the FIFO is empty.
REQ-019 CLEAR SHALL assert InDMAReset (InDMAValid=0) for addresses 0..BlocksOnPath-1, one per cycle, then pulse Done one cycle and return to IDLE.
REQ-020 Counters SHALL terminate exactly at StashCapacity-1 / BlocksOnPath-1 with no wrap; Start during Busy SHALL have no effect.
Reset
REQ-021 Reset SHALL force IDLE at any state, empty FIFO, clear in-flight tracking, counters and AcceptedCount, and drive all outputs 0 the next cycle (CurrentLeaf 0).
REQ-022 Reset mid-DRAIN SHALL discard the pending OutDMAValid response; the scan table is recleared by its own reset.
Configuration
REQ-023 With STASH_SCAN_SKIPNULL_EN defined, OutDMAAddr==SNULL responses SHALL NOT enqueue; without it every response enqueues, SNULL included.
Verification
REQ-024 ORAML=4,ORAMZ=2,StashCapacity=16: entries 3,7 valid on leaf=StartLeaf -> AcceptedCount=2, WB emits 7,3 per table order (SKIPNULL), Done after CLEAR.
REQ-025 Same, SKIPNULL undefined -> exactly 10 WB transfers, 8 equal SNULL.
REQ-026 WBReady toggled 1-of-3 cycles in DRAIN -> no loss/duplication; InDMAValid never issued with 2 outstanding.
REQ-027 Start with ResetDone=0 -> ignored, Busy=1; Start during SCAN -> ignored, CurrentLeaf unchanged.
REQ-028 Reset asserted in DRAIN cycle 5 -> next cycle IDLE, all outputs 0; new Start completes normally.
REQ-029 Every CLEAR -> 10 InDMAReset cycles, addresses 0..9, then Done pulse exactly one cycle.

Source files
------------

// File: rtl/stash_scan_scheduler.sv
// stash_scan_scheduler: per-access sequencer that scans the stash into the scan table, drains the table to writeback, then clears it.
//
// Optional feature: define STASH_SCAN_SKIPNULL_EN to drop SNULL drain responses instead of forwarding them to writeback.
//
// Ports:
//   Clock, Reset                    single clock, synchronous active-high reset
//   Start, StartLeaf                access request and its leaf (accepted only when idle and ResetDone)
//   Busy, Done, AcceptedCount       access in progress, one-cycle completion pulse, entries accepted this access
//   MetaAddr, MetaRead              stash metadata read request
//   MetaValid, MetaLeaf, MetaPAddr  stash metadata response, one cycle after MetaRead
//   PerAccessReset                  one-cycle scan-table reset at access start
//   CurrentLeaf, CurrentLeafValid   leaf of the access in progress
//   InScan*                         scan-table candidate entry
//   InDMAAddr/Valid/Reset           scan-table read (drain) or clear (per address)
//   ResetDone, OutScanAccepted      scan-table ready, candidate accepted
//   OutDMAAddr, OutDMAValid         scan-table read response, one cycle after InDMAValid
//   WBSAddr, WBValid, WBReady       writeback stream, transfer on WBValid & WBReady
module stash_scan_scheduler #(
    parameter int ORAML = 32,
    parameter int ORAMU = 32,
    parameter int ORAMZ = 4,
    parameter int StashEAWidth = 7,
    parameter int StashCapacity = 100,
    parameter int ScanTableAWidth = 8,
    parameter int BlocksOnPath = (ORAML + 1) * ORAMZ,
    parameter logic [StashEAWidth-1:0] SNULL = '1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic [ORAML-1:0]           StartLeaf,
    output logic                       Busy,
    output logic                       Done,
    output logic [StashEAWidth-1:0]    AcceptedCount,
    output logic [StashEAWidth-1:0]    MetaAddr,
    output logic                       MetaRead,
    input  logic                       MetaValid,
    input  logic [ORAML-1:0]           MetaLeaf,
    input  logic [ORAMU-1:0]           MetaPAddr,
    output logic                       PerAccessReset,
    output logic [ORAML-1:0]           CurrentLeaf,
    output logic                       CurrentLeafValid,
    output logic [ORAML-1:0]           InScanLeaf,
    output logic [ORAMU-1:0]           InScanPAddr,
    output logic [StashEAWidth-1:0]    InScanSAddr,
    output logic                       InScanValid,
    output logic [ScanTableAWidth-1:0] InDMAAddr,
    output logic                       InDMAValid,
    output logic                       InDMAReset,
    input  logic                       ResetDone,
    input  logic                       OutScanAccepted,
    input  logic [StashEAWidth-1:0]    OutDMAAddr,
    input  logic                       OutDMAValid,
    output logic [StashEAWidth-1:0]    WBSAddr,
    output logic                       WBValid,
    input  logic                       WBReady
);
    localparam logic [StashEAWidth-1:0] LastMeta = StashEAWidth'(StashCapacity - 1);
    localparam logic [ScanTableAWidth-1:0] LastEntry = ScanTableAWidth'(BlocksOnPath - 1);

    typedef enum logic [2:0] {IDLE, PRESET, SCAN, DRAIN, CLEAR} stateType;
    stateType state, nextState;

    logic accept, readsDone, rspValid, dmaPending, issuedAll, canIssue, dmaKeep, enq, deq;
    logic [StashEAWidth-1:0] rspAddr;
    logic [ScanTableAWidth-1:0] tableAddr;
    logic [StashEAWidth-1:0] fifoMem [2];
    logic wrPtr, rdPtr;
    logic [1:0] fifoCount;

`ifdef STASH_SCAN_SKIPNULL_EN
    assign dmaKeep = OutDMAAddr != SNULL;
`else
    assign dmaKeep = 1'b1;
`endif

    always_comb begin
        nextState = state;
        accept = 1'b0;
        case (state)
            IDLE: begin
                accept = Start & ResetDone;
                nextState = (Start & ResetDone) ? PRESET : IDLE;
            end
            PRESET: nextState = SCAN;
            // readsDone is already set during the response cycle of the last read
            SCAN: nextState = readsDone ? DRAIN : SCAN;
            DRAIN: nextState = (issuedAll & ~dmaPending & fifoCount == 2'd0) ? CLEAR : DRAIN;
            CLEAR: nextState = (tableAddr == LastEntry) ? IDLE : CLEAR;
            default: nextState = IDLE;
        endcase
    end

    assign Busy = (state != IDLE) | ~ResetDone;
    assign PerAccessReset = state == PRESET;
    assign CurrentLeafValid = (state == SCAN) | (state == DRAIN);
    assign MetaRead = (state == SCAN) & ~readsDone;
    assign InScanValid = rspValid & MetaValid;
    assign InScanSAddr = rspValid ? rspAddr : '0;
    assign InScanLeaf = rspValid ? MetaLeaf : '0;
    assign InScanPAddr = rspValid ? MetaPAddr : '0;
    // FIFO slots already taken plus the read in flight must leave room for one more
    assign canIssue = (fifoCount == 2'd0) | ((fifoCount == 2'd1) & ~dmaPending);
    assign InDMAValid = (state == DRAIN) & ~issuedAll & canIssue;
    assign InDMAReset = state == CLEAR;
    assign InDMAAddr = (InDMAValid | InDMAReset) ? tableAddr : '0;
    // dmaPending gating drops a response whose read was issued before a reset
    assign enq = (state == DRAIN) & dmaPending & OutDMAValid & dmaKeep;
    assign WBValid = fifoCount != 2'd0;
    assign WBSAddr = WBValid ? fifoMem[rdPtr] : '0;
    assign deq = WBValid & WBReady;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Done <= 1'b0;
            CurrentLeaf <= '0;
            AcceptedCount <= '0;
            MetaAddr <= '0;
            readsDone <= 1'b0;
            rspValid <= 1'b0;
            rspAddr <= '0;
            dmaPending <= 1'b0;
            issuedAll <= 1'b0;
            tableAddr <= '0;
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            fifoCount <= 2'd0;
        end else begin
            Done <= (state == CLEAR) & (tableAddr == LastEntry);
            rspValid <= MetaRead;
            rspAddr <= MetaAddr;
            dmaPending <= InDMAValid;
            if (accept) begin
                CurrentLeaf <= StartLeaf;
                AcceptedCount <= '0;
                MetaAddr <= '0;
                readsDone <= 1'b0;
                issuedAll <= 1'b0;
                tableAddr <= '0;
            end
            if ((state == SCAN) & OutScanAccepted) AcceptedCount <= AcceptedCount + 1'b1;
            if (MetaRead) begin
                if (MetaAddr == LastMeta) readsDone <= 1'b1;
                else MetaAddr <= MetaAddr + 1'b1;
            end
            if (InDMAValid) begin
                if (tableAddr == LastEntry) issuedAll <= 1'b1;
                else tableAddr <= tableAddr + 1'b1;
            end
            if ((state == DRAIN) & (nextState == CLEAR)) tableAddr <= '0;
            if (InDMAReset & (tableAddr != LastEntry)) tableAddr <= tableAddr + 1'b1;
            if (enq) wrPtr <= ~wrPtr;
            if (deq) rdPtr <= ~rdPtr;
            fifoCount <= fifoCount + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge Clock) begin
        if (enq) fifoMem[wrPtr] <= OutDMAAddr;
    end
endmodule

// File: tb/tb_stash_scan_scheduler.sv
// tb_stash_scan_scheduler: directed bench for stash_scan_scheduler with stash and scan-table models.
module tb_stash_scan_scheduler;
    localparam int L = 4, U = 32, EA = 7, TA = 8, Cap = 16, Bop = 10;
    localparam logic [EA-1:0] Null = '1;

    logic Clock, Reset, Start, Busy, Done, MetaRead, MetaValid, PerAccessReset, CurrentLeafValid;
    logic InScanValid, InDMAValid, InDMAReset, ResetDone, OutScanAccepted, OutDMAValid, WBValid, WBReady;
    logic [L-1:0] StartLeaf, MetaLeaf, CurrentLeaf, InScanLeaf;
    logic [U-1:0] MetaPAddr, InScanPAddr;
    logic [EA-1:0] AcceptedCount, MetaAddr, InScanSAddr, OutDMAAddr, WBSAddr;
    logic [TA-1:0] InDMAAddr;

    stash_scan_scheduler #(
        .ORAML(L), .ORAMU(U), .ORAMZ(2), .StashEAWidth(EA), .StashCapacity(Cap), .ScanTableAWidth(TA)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .StartLeaf(StartLeaf), .Busy(Busy), .Done(Done),
        .AcceptedCount(AcceptedCount), .MetaAddr(MetaAddr), .MetaRead(MetaRead), .MetaValid(MetaValid),
        .MetaLeaf(MetaLeaf), .MetaPAddr(MetaPAddr), .PerAccessReset(PerAccessReset),
        .CurrentLeaf(CurrentLeaf), .CurrentLeafValid(CurrentLeafValid), .InScanLeaf(InScanLeaf),
        .InScanPAddr(InScanPAddr), .InScanSAddr(InScanSAddr), .InScanValid(InScanValid),
        .InDMAAddr(InDMAAddr), .InDMAValid(InDMAValid), .InDMAReset(InDMAReset), .ResetDone(ResetDone),
        .OutScanAccepted(OutScanAccepted), .OutDMAAddr(OutDMAAddr), .OutDMAValid(OutDMAValid),
        .WBSAddr(WBSAddr), .WBValid(WBValid), .WBReady(WBReady)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checkCount = 0, errorCount = 0;
    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    logic stashValid [128];
    logic [L-1:0] stashLeaf [128];
    always @(posedge Clock) begin
        MetaValid <= MetaRead && stashValid[MetaAddr];
        MetaLeaf <= stashLeaf[MetaAddr];
        MetaPAddr <= 32'(MetaAddr) + 32'd100;
    end

    // scan table: accepted blocks fill from the top slot downward
    logic [EA-1:0] scanTable [256];
    int accIdx;
    assign OutScanAccepted = InScanValid && (InScanLeaf == CurrentLeaf);
    always @(posedge Clock) begin
        OutDMAValid <= InDMAValid;
        OutDMAAddr <= scanTable[InDMAAddr];
        if (Reset || PerAccessReset) begin
            for (int i = 0; i < 256; i++) scanTable[i] <= Null;
            accIdx <= 0;
        end else begin
            if (OutScanAccepted) begin
                scanTable[Bop - 1 - accIdx] <= InScanSAddr;
                accIdx <= accIdx + 1;
            end
            if (InDMAReset) scanTable[InDMAAddr] <= Null;
        end
    end

    logic wbMode;
    int cyc = 0;
    initial begin
        WBReady = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            cyc++;
            WBReady = wbMode ? (cyc % 3 == 0) : 1'b1;
        end
    end

    logic [EA-1:0] wbSeen [$];
    int clrSeen [$];
    int doneCycles = 0, preCycles = 0, held = 0, dmaViolations = 0, mixViolations = 0;
    logic keep;
    always @(negedge Clock) begin
        if (InScanValid && (InDMAValid || InDMAReset)) mixViolations++;
        if (InDMAValid && (held + (OutDMAValid ? 1 : 0) >= 2)) dmaViolations++;
        if (WBValid && WBReady) wbSeen.push_back(WBSAddr);
        if (InDMAReset) clrSeen.push_back(int'(InDMAAddr));
        if (Done) doneCycles++;
        if (PerAccessReset) preCycles++;
`ifdef STASH_SCAN_SKIPNULL_EN
        keep = OutDMAAddr != Null;
`else
        keep = 1'b1;
`endif
        held = held + ((OutDMAValid && keep) ? 1 : 0) - ((WBValid && WBReady) ? 1 : 0);
    end

    task automatic setup(input logic [L-1:0] leaf, input logic slow);
        wbSeen.delete();
        clrSeen.delete();
        doneCycles = 0;
        preCycles = 0;
        held = 0;
        wbMode = slow;
        for (int i = 0; i < 128; i++) begin
            stashValid[i] = 1'b0;
            stashLeaf[i] = '0;
        end
        stashValid[3] = 1'b1;
        stashLeaf[3] = leaf;
        stashValid[7] = 1'b1;
        stashLeaf[7] = leaf;
        stashValid[11] = 1'b1;
        stashLeaf[11] = ~leaf;
    endtask

    task automatic runAccess(input logic [L-1:0] leaf, input logic slow, input string tag);
        int n;
        logic [EA-1:0] expWb [$];
        setup(leaf, slow);
`ifndef STASH_SCAN_SKIPNULL_EN
        for (int i = 0; i < 8; i++) expWb.push_back(Null);
`endif
        expWb.push_back(7'd7);
        expWb.push_back(7'd3);
        Start = 1'b1;
        StartLeaf = leaf;
        step();
        Start = 1'b0;
        checkValue({tag, "_preset"}, 32'(PerAccessReset), 1);
        checkValue({tag, "_leaf"}, 32'(CurrentLeaf), 32'(leaf));
        checkValue({tag, "_acc_clear"}, 32'(AcceptedCount), 0);
        step();
        checkValue({tag, "_scan_read"}, 32'({MetaRead, CurrentLeafValid, PerAccessReset}), 32'b110);
        checkValue({tag, "_scan_addr0"}, 32'(MetaAddr), 0);
        step();
        step();
        Start = 1'b1;
        StartLeaf = ~leaf;
        step();
        Start = 1'b0;
        checkValue({tag, "_leaf_hold"}, 32'(CurrentLeaf), 32'(leaf));
        n = 0;
        while (!Done && n < 600) begin
            step();
            n++;
        end
        checkValue({tag, "_done_seen"}, 32'(n < 600), 1);
        step();
        step();
        checkValue({tag, "_done_width"}, 32'(doneCycles), 1);
        checkValue({tag, "_preset_once"}, 32'(preCycles), 1);
        checkValue({tag, "_accepted"}, 32'(AcceptedCount), 2);
        checkValue({tag, "_busy_end"}, 32'(Busy), 0);
        checkValue({tag, "_wb_count"}, 32'(wbSeen.size()), 32'(expWb.size()));
        for (int i = 0; i < expWb.size(); i++)
            if (i < wbSeen.size()) checkValue({tag, "_wb_data"}, 32'(wbSeen[i]), 32'(expWb[i]));
        checkValue({tag, "_clr_count"}, 32'(clrSeen.size()), Bop);
        for (int i = 0; i < clrSeen.size(); i++) checkValue({tag, "_clr_addr"}, 32'(clrSeen[i]), 32'(i));
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        Start = 1'b0;
        StartLeaf = '0;
        ResetDone = 1'b1;
        wbMode = 1'b0;
        setup(4'd0, 1'b0);
        step();
        step();
        Reset = 1'b0;
        step();
        checkValue("reset_busy", 32'(Busy), 0);
        checkValue("reset_leaf", 32'(CurrentLeaf), 0);
        checkValue("reset_outs", 32'(|{Done, AcceptedCount, MetaAddr, MetaRead, PerAccessReset, CurrentLeafValid,
            InScanValid, InDMAAddr, InDMAValid, InDMAReset, WBSAddr, WBValid}), 0);

        ResetDone = 1'b0;
        Start = 1'b1;
        StartLeaf = 4'd9;
        step();
        Start = 1'b0;
        checkValue("nrd_busy", 32'(Busy), 1);
        checkValue("nrd_no_preset", 32'(PerAccessReset), 0);
        step();
        checkValue("nrd_no_scan", 32'({MetaRead, PerAccessReset, CurrentLeafValid}), 0);
        ResetDone = 1'b1;
        step();
        checkValue("nrd_idle", 32'(Busy), 0);

        runAccess(4'd5, 1'b0, "a");
        runAccess(4'd10, 1'b1, "b");

        setup(4'd6, 1'b1);
        Start = 1'b1;
        StartLeaf = 4'd6;
        step();
        Start = 1'b0;
        n = 0;
        while (!InDMAValid && n < 200) begin
            step();
            n++;
        end
        checkValue("rd_drain_seen", 32'(n < 200), 1);
        repeat (4) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checkValue("rd_busy", 32'(Busy), 0);
        checkValue("rd_leaf", 32'(CurrentLeaf), 0);
        checkValue("rd_outs", 32'(|{Done, AcceptedCount, MetaAddr, MetaRead, PerAccessReset, CurrentLeafValid,
            InScanValid, InDMAAddr, InDMAValid, InDMAReset, WBSAddr, WBValid}), 0);
        step();
        checkValue("rd_discard", 32'(WBValid), 0);

        runAccess(4'd3, 1'b1, "c");

        checkValue("scan_dma_overlap", 32'(mixViolations), 0);
        checkValue("dma_outstanding", 32'(dmaViolations), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
